fetch_sequencer: RTL

- Fetch-stage controller that owns the fetch PC and sequences it against the instruction-memory request/grant/response handshake.
- Sits between the next-PC sources (sequential +4, branch/jump redirect from execute) and the decode stage.
- Presents one fetched instruction at a time to decode, with its PC.
- Handles decode back-pressure and discards in-flight fetches on redirect.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/program_counter_reg.sv | 35 +++
 rtl/fetch_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// The FAULT state is only reachable when FETCH_MISALIGN_CHK_EN is defined.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        VALID   = 3'd3,
        DISCARD = 3'd4,
        FAULT   = 3'd5
    } fetch_state_e;

    localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/program_counter_reg.sv
// Fetch PC register: loads pc_next_i unless held, resets to RESET_PC.
module program_counter_reg
    import fetch_pkg::*;
#(
    parameter int unsigned           PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic [PC_WIDTH-1:0] pc_next_i,
    output logic [PC_WIDTH-1:0] pc_o
);

    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (!stall_i) begin
            pc_d = pc_next_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: sequences the fetch PC over a req/gnt/rvalid imem port.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned redirects into a sticky FAULT state.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned           PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                redirect_valid_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    output logic                imem_req_o,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [31:0]         imem_rdata_i,
    output logic                instr_valid_o,
    output logic [31:0]         instr_o,
    output logic [PC_WIDTH-1:0] instr_pc_o,
    output logic                fetch_fault_o
);

    fetch_state_e        state_q, state_d;
    logic                req_q, req_d;
    logic                valid_q, valid_d;
    logic                fault_q, fault_d;
    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] instr_pc_q, instr_pc_d;

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] redirect_tgt;
    logic                misalign;
    logic                take_redirect;
    logic                advance;

`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign redirect_tgt  = redirect_pc_i & ~PC_WIDTH'(3);
    assign take_redirect = redirect_valid_i && (state_q != FAULT) && !misalign;
    assign advance       = (state_q == VALID) && !stall_i && !redirect_valid_i;
    assign pc_next       = take_redirect ? redirect_tgt : pc_q + PC_WIDTH'(PC_INCR);

    program_counter_reg #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_i   (!(advance || take_redirect)),
        .pc_next_i (pc_next),
        .pc_o      (pc_q)
    );

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        fault_d    = fault_q;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt_i) begin
                    // A granted request owes a response even if redirected away.
                    state_d = redirect_valid_i ? DISCARD : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    if (redirect_valid_i) begin
                        state_d = REQ;
                    end else begin
                        instr_d    = imem_rdata_i;
                        instr_pc_d = pc_q;
                        state_d    = VALID;
                    end
                end else if (redirect_valid_i) begin
                    state_d = DISCARD;
                end
            end
            VALID: begin
                if (redirect_valid_i || !stall_i) begin
                    state_d = REQ;
                end
            end
            DISCARD: begin
                if (imem_rvalid_i) begin
                    state_d = REQ;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase

        if (misalign && (state_q != FAULT)) begin
            state_d = FAULT;
            fault_d = 1'b1;
        end
    end

    assign req_d   = (state_d == REQ);
    assign valid_d = (state_d == VALID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign fetch_fault_o = fault_q;

endmodule
